// File: rtl/key_toggle_debounce_if.sv
// Key/toggle bundle between the TM1638 scanner, the debouncer and its consumers.
// The master side drives raw keys and clear; the slave side returns debounced results.
interface key_toggle_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] keys;
  logic             clear;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] state;

  modport master (output keys, output clear, input stable, input pressed, input state);
  modport slave  (input keys, input clear, output stable, output pressed, output state);
endinterface

// File: rtl/key_toggle_debounce.sv
// Per-key debounce, press-edge pulse and toggle latch for the TM1638 key row.
// Optional auto-repeat of held keys is enabled by defining KEY_TOGGLE_AUTOREPEAT_EN.
module key_toggle_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int CNT_W           = 16
`ifdef KEY_TOGGLE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 3000000,
  parameter int REPEAT_RATE     = 600000
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  key_toggle_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] keys_q;
  logic [WIDTH-1:0] stable_q,  stable_d;
  logic [WIDTH-1:0] pressed_q, pressed_d;
  logic [WIDTH-1:0] state_q,   state_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] rise;

`ifdef KEY_TOGGLE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
  localparam logic [RPT_W-1:0] DELAY_LD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LD  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic [RPT_W-1:0] rpt_q [WIDTH];
  logic [RPT_W-1:0] rpt_d [WIDTH];
  logic [WIDTH-1:0] rpt_fire;
`endif

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (keys_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        stable_d[i] = keys_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign rise = stable_d & ~stable_q;

`ifdef KEY_TOGGLE_AUTOREPEAT_EN
  // Down-counter per key: loaded on the press edge, fires and reloads at zero while held.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rpt_d[i] = rpt_q[i];
      if (rise[i]) begin
        rpt_d[i] = DELAY_LD;
      end else if (stable_q[i] && stable_d[i]) begin
        if (rpt_q[i] == '0) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RATE_LD;
        end else begin
          rpt_d[i] = rpt_q[i] - RPT_ONE;
        end
      end
    end
  end

  assign pressed_d = rise | rpt_fire;
`else
  assign pressed_d = rise;
`endif

  // Clear beats a simultaneous toggle, but the press pulse still goes out.
  assign state_d = bus.clear ? '0 : (state_q ^ pressed_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      keys_q    <= '0;
      stable_q  <= '0;
      pressed_q <= '0;
      state_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      keys_q    <= bus.keys;
      stable_q  <= stable_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEY_TOGGLE_AUTOREPEAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end
`endif

  assign bus.stable  = stable_q;
  assign bus.pressed = pressed_q;
  assign bus.state   = state_q;

endmodule
